bcd_decoder: RTL and testbench

Sequential reverse double-dabble converter: accepts a 4-digit packed BCD value (0–9999) and produces its 16-bit unsigned binary equivalent, one bit per clock. It is the inverse of the display-path binary-to-BCD encoder. It sits on the input path, where operator or host-entered decimal digits are turned back into binary operands for the core. It uses the same single-pulse start / level done handshake as the encoder, so both blocks share one controller idiom.

---
 rtl/bcd_decoder_if.sv | 24 ++
 rtl/bcd_decoder.sv | 100 ++++++++++
 tb/tb_bcd_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_decoder_if.sv
// Start/done handshake and data bus between a host and the BCD-to-binary decoder.
interface bcd_decoder_if;
    logic        i_begin_conv;
    logic [15:0] i_bcd;
    logic        o_conv_done;
    logic [15:0] o_binary;
    logic        o_bcd_err;

    modport master (
        output i_begin_conv,
        output i_bcd,
        input  o_conv_done,
        input  o_binary,
        input  o_bcd_err
    );

    modport slave (
        input  i_begin_conv,
        input  i_bcd,
        output o_conv_done,
        output o_binary,
        output o_bcd_err
    );
endinterface

// File: rtl/bcd_decoder.sv
// Sequential reverse double-dabble: 4-digit packed BCD to 16-bit binary, one bit per clock.
// Optional BCD_DECODER_DIGIT_CHECK_EN rejects requests containing a nibble above 9.
//
// state    | meaning
// ST_IDLE  | o_conv_done=1, result held, waiting for i_begin_conv
// ST_SHIFT | 16 shift/correct cycles counted by conv_ctr
module bcd_decoder (
    input  logic          i_clk,
    input  logic          i_rst,
    bcd_decoder_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  conv_ctr_q, conv_ctr_d;
    logic [31:0] work_q, work_d;
    logic [15:0] binary_q, binary_d;
    logic        bcd_err_q, bcd_err_d;

    logic [31:0] shifted;
    logic [31:0] corrected;
    logic        digit_bad;

    // Shift right, then pull 3 out of every BCD nibble that reached 8 or more.
    always_comb begin
        shifted   = {1'b0, work_q[31:1]};
        corrected = shifted;
        for (int k = 0; k < 4; k++) begin
            if (shifted[16 + 4*k +: 4] >= 4'd8)
                corrected[16 + 4*k +: 4] = shifted[16 + 4*k +: 4] - 4'd3;
        end
    end

`ifdef BCD_DECODER_DIGIT_CHECK_EN
    always_comb begin
        digit_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.i_bcd[4*k +: 4] > 4'd9)
                digit_bad = 1'b1;
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            conv_ctr_q <= 5'd0;
            work_q     <= 32'd0;
            binary_q   <= 16'd0;
            bcd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_ctr_q <= conv_ctr_d;
            work_q     <= work_d;
            binary_q   <= binary_d;
            bcd_err_q  <= bcd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_ctr_d = conv_ctr_q;
        work_d     = work_q;
        binary_d   = binary_q;
        bcd_err_d  = bcd_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_begin_conv) begin
                    if (digit_bad) begin
                        // Rejected request completes in place; done never drops.
                        bcd_err_d = 1'b1;
                        binary_d  = 16'hFFFF;
                    end else begin
                        state_d    = ST_SHIFT;
                        work_d     = {bus.i_bcd, 16'd0};
                        conv_ctr_d = 5'd0;
                        binary_d   = 16'd0;
                        bcd_err_d  = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                work_d     = corrected;
                conv_ctr_d = conv_ctr_q + 5'd1;
                if (conv_ctr_q == 5'd15) begin
                    binary_d   = corrected[15:0];
                    conv_ctr_d = 5'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_conv_done = (state_q == ST_IDLE);
    assign bus.o_binary    = binary_q;
    assign bus.o_bcd_err   = bcd_err_q;
endmodule

// File: tb/tb_bcd_decoder.sv
// Self-checking bench for bcd_decoder: directed handshake cases plus random BCD values
// checked against a decimal-arithmetic reference.
module tb_bcd_decoder;
    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    bcd_decoder_if bus ();

    bcd_decoder dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] ref_value(input logic [15:0] bcd);
        int v;
        v = 1000 * int'(bcd[15:12]) + 100 * int'(bcd[11:8]) + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept edge E0, then step to E16 checking done timing and the result.
    task automatic run_conv(input string tag, input logic [15:0] bcd, input logic [15:0] exp);
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = bcd;
        @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        bus.i_bcd        = 16'h0000;
        check({tag, "_busy_E0"}, 32'(bus.o_conv_done), 32'd0);
        check({tag, "_bin_clr"}, 32'(bus.o_binary), 32'd0);
        repeat (15) @(posedge i_clk);
        #1;
        check({tag, "_busy_E15"}, 32'(bus.o_conv_done), 32'd0);
        @(posedge i_clk);
        #1;
        check({tag, "_done_E16"}, 32'(bus.o_conv_done), 32'd1);
        check({tag, "_bin"}, 32'(bus.o_binary), 32'(exp));
        check({tag, "_err"}, 32'(bus.o_bcd_err), 32'd0);
    endtask

    initial begin
        logic [15:0] rbcd;
        checks           = 0;
        errors           = 0;
        i_rst            = 1'b1;
        bus.i_begin_conv = 1'b0;
        bus.i_bcd        = 16'h0000;

        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_done", 32'(bus.o_conv_done), 32'd1);
        check("rst_bin", 32'(bus.o_binary), 32'h0);
        check("rst_err", 32'(bus.o_bcd_err), 32'd0);

        run_conv("c9999", 16'h9999, 16'h270F);
        run_conv("c1234", 16'h1234, 16'h04D2);
        run_conv("c0000", 16'h0000, 16'h0000);

        // Busy ignore: second request at E5 must be dropped.
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = 16'h0042;
        @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = 16'h9999;
        @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        bus.i_bcd        = 16'h0000;
        repeat (10) @(posedge i_clk);
        #1;
        check("busy_E15", 32'(bus.o_conv_done), 32'd0);
        @(posedge i_clk);
        #1;
        check("busy_done", 32'(bus.o_conv_done), 32'd1);
        check("busy_bin", 32'(bus.o_binary), 32'h002A);
        repeat (3) @(posedge i_clk);
        #1;
        check("busy_no_restart", 32'(bus.o_conv_done), 32'd1);
        check("busy_hold", 32'(bus.o_binary), 32'h002A);

        // Back-to-back with request held high.
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = 16'h0100;
        @(posedge i_clk);
        #1;
        check("b2b_busy0", 32'(bus.o_conv_done), 32'd0);
        repeat (15) @(posedge i_clk);
        #1;
        check("b2b_busy15", 32'(bus.o_conv_done), 32'd0);
        @(posedge i_clk);
        #1;
        check("b2b_done1", 32'(bus.o_conv_done), 32'd1);
        check("b2b_bin1", 32'(bus.o_binary), 32'h0064);
        @(posedge i_clk);
        #1;
        check("b2b_restart", 32'(bus.o_conv_done), 32'd0);
        repeat (16) @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        check("b2b_done2", 32'(bus.o_conv_done), 32'd1);
        check("b2b_bin2", 32'(bus.o_binary), 32'h0064);
        @(posedge i_clk);
        #1;
        check("b2b_stop", 32'(bus.o_conv_done), 32'd1);

        // Reset at E8 aborts the conversion.
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = 16'h5678;
        @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        repeat (7) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("mrst_done", 32'(bus.o_conv_done), 32'd1);
        check("mrst_bin", 32'(bus.o_binary), 32'h0);
        check("mrst_err", 32'(bus.o_bcd_err), 32'd0);
        repeat (20) @(posedge i_clk);
        #1;
        check("mrst_quiet", 32'(bus.o_conv_done), 32'd1);
        run_conv("c5678", 16'h5678, 16'h162E);

`ifdef BCD_DECODER_DIGIT_CHECK_EN
        @(negedge i_clk);
        bus.i_begin_conv = 1'b1;
        bus.i_bcd        = 16'h12A4;
        @(posedge i_clk);
        #1;
        bus.i_begin_conv = 1'b0;
        check("dchk_done", 32'(bus.o_conv_done), 32'd1);
        check("dchk_err", 32'(bus.o_bcd_err), 32'd1);
        check("dchk_bin", 32'(bus.o_binary), 32'hFFFF);
        run_conv("dchk_ok", 16'h0007, 16'h0007);
`endif

        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 4; d++)
                rbcd[4*d +: 4] = 4'($urandom_range(9, 0));
            run_conv("rand", rbcd, ref_value(rbcd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
